display_scan_mux: RTL

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_scan_mux_pkg.sv | 23 ++
 rtl/display_scan_mux_hex7_decode.sv | 18 +
 rtl/display_scan_mux.sv | 112 +++++++++++
 3 files changed

// File: rtl/display_scan_mux_pkg.sv
// ============================================================================
// display_scan_mux_pkg : shared constants and types for the 8-digit scan mux
// Revision : 1.0
// ============================================================================
`default_nettype none

package display_scan_mux_pkg;

  typedef logic [2:0] digit_idx_t;

  // Segment and anode drives are active-low, so "off" is all ones.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Hex digit to segments {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/display_scan_mux_hex7_decode.sv
// ============================================================================
// hex7_decode : combinational hex nibble to active-low 7-segment pattern
// Revision : 1.0
// ============================================================================
`default_nettype none

module hex7_decode
  import display_scan_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/display_scan_mux.sv
// ============================================================================
// display_scan_mux : 8-digit multiplexed 7-segment scanner with frame-aligned
//                    load handshake. Optional macro LEADING_ZERO_BLANK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  localparam int         CNT_W      = $clog2(REFRESH_DIV);
  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_presc;
  digit_idx_t              r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic                    r_pend_full;

  logic       w_tick;
  logic       w_wrap;
  logic       w_load_fire;
  logic       w_lz_blank;
  logic       w_blank;
  logic [3:0] w_nibble;
  logic [6:0] w_seg;

  assign w_tick      = (r_presc == CNT_W'(REFRESH_DIV - 1));
  assign w_wrap      = w_tick && (r_idx == LAST_DIGIT);
  assign load_ready  = ~r_pend_full;
  assign w_load_fire = load_valid && ~r_pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Pending only drains on a frame wrap, so one frame never shows two values.
  // A capture cannot coincide with a drain because ready is low while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp      <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else if (w_wrap && r_pend_full) begin
      r_disp      <= r_pend;
      r_pend_full <= 1'b0;
    end else if (w_load_fire) begin
      r_pend      <= load_data;
      r_pend_full <= 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  digit_idx_t w_msd;

  always_comb begin
    w_msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (r_disp[4*i +: 4] != 4'h0) w_msd = digit_idx_t'(i);
    end
  end

  assign w_lz_blank = (r_idx > w_msd);
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_blank  = ~digit_en[r_idx] | w_lz_blank;
  assign w_nibble = r_disp[4*r_idx +: 4];

  hex7_decode u_hex7_decode (
    .nibble (w_nibble),
    .seg    (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else if (w_blank) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << r_idx);
      seg <= w_seg;
    end
  end

endmodule

`default_nettype wire
